// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op codes, state encoding and helpers for the shift sequencer
// Optional rotate support: SHIFT_SEQ_ROTATE_EN
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic bit step_bits_legal(input int step_bits);
        return (step_bits == 1) || (step_bits == 2) || (step_bits == 4) || (step_bits == 8);
    endfunction

    // Shifts saturate at the word width and ignore negative counts; rotates
    // only care about the count modulo 32. Anything unsupported becomes a no-op.
    function automatic logic [CNT_W-1:0] effective_amount(input logic [2:0]        op,
                                                          input logic [DATA_W-1:0] amount);
        logic [CNT_W-1:0] eff;
        eff = '0;
        case (op)
            OP_SHR, OP_SHRA, OP_SHL: begin
                if (amount[DATA_W-1])
                    eff = '0;
                else if (amount > 32'd32)
                    eff = 6'd32;
                else
                    eff = amount[CNT_W-1:0];
            end
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR, OP_ROL: eff = {1'b0, amount[4:0]};
`endif
            default: eff = '0;
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter (up to 8 positions per step)
// Rotate paths exist only when SHIFT_SEQ_ROTATE_EN is defined
module shift_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] value_i,
    input  logic [2:0]        op_i,
    input  logic [3:0]        step_i,
    output logic [DATA_W-1:0] value_o
);

`ifdef SHIFT_SEQ_ROTATE_EN
    logic [2*DATA_W-1:0] wide;
`endif

    always_comb begin
        value_o = value_i;
`ifdef SHIFT_SEQ_ROTATE_EN
        wide    = '0;
`endif
        case (op_i)
            OP_SHR:  value_o = value_i >> step_i;
            OP_SHRA: value_o = $unsigned($signed(value_i) >>> step_i);
            OP_SHL:  value_o = value_i << step_i;
`ifdef SHIFT_SEQ_ROTATE_EN
            // Doubling the word lets a plain shift carry the wrapped-out bits.
            OP_ROR: begin
                wide    = {value_i, value_i} >> step_i;
                value_o = wide[DATA_W-1:0];
            end
            OP_ROL: begin
                wide    = {value_i, value_i} << step_i;
                value_o = wide[2*DATA_W-1:DATA_W];
            end
`endif
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shifter: IDLE/SHIFT/DONE sequencer around shift_step
// Rotate ops (ror/rol) are compiled in only with SHIFT_SEQ_ROTATE_EN
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP_BITS = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] shift_amount,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    generate
        if (!step_bits_legal(STEP_BITS)) begin : g_bad_step
            $error("shift_sequencer: STEP_BITS must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_BITS);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic [3:0]        step_n;
    logic [DATA_W-1:0] stepped;

    // The final step of an operation may be shorter than STEP_BITS.
    assign step_n = (count_q < STEP_C) ? count_q[3:0] : STEP_C[3:0];

    shift_step u_step (
        .value_i (work_q),
        .op_i    (op_q),
        .step_i  (step_n),
        .value_o (stepped)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            op_q       <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            op_q       <= op_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        op_d       = op_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    work_d  = data_in;
                    op_d    = op;
                    count_d = effective_amount(op, shift_amount);
                end
            end
            ST_SHIFT: begin
                if (count_q == '0) begin
                    state_d    = ST_DONE;
                    data_out_d = work_q;
                end else begin
                    work_d  = stepped;
                    count_d = count_q - {2'b00, step_n};
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign data_out = data_out_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter STEP_BITS, default 1, meaning bit positions shifted per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port clear  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  operation: 000 shr (logical), 001 shra (arithmetic), 010 shl, 011 ror, 100 rol.
REQ-006 SHALL have port data_in  input  32  signed operand, captured on accepted start.
REQ-007 SHALL have port shift_amount  input  32  signed shift count, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking data_out valid.
REQ-010 SHALL have port data_out  output  32  result register.

Function
REQ-011 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on start=1; SHIFT->DONE when remaining count is 0; DONE->IDLE unconditionally.
REQ-012 SHALL, on accepted start, load a work register with data_in, latch op, and load count = effective amount.
REQ-013 SHALL compute effective amount for shr/shra/shl as min(shift_amount, 32), with negative shift_amount treated as 0.
REQ-014 SHALL compute effective amount for ror/rol as shift_amount[4:0].
REQ-015 SHALL, in each SHIFT cycle with count>0, shift the work register by min(STEP_BITS, count) and decrement count by the same amount.
REQ-016 SHALL fill with zeros for shr/shl, with copies of bit 31 for shra, and with wrapped-out bits for ror/rol.
REQ-017 SHALL, for start accepted at edge k, assert done during the cycle following edge k+ceil(count/STEP_BITS)+1; amount 0 gives done after edge k+1.
REQ-018 SHALL copy the work register to data_out on entry to DONE, and hold data_out until the next DONE.
REQ-019 SHALL ignore start while busy=1, including during the DONE cycle.
REQ-020 SHALL treat op values 101-111 as amount 0, so data_out = data_in.

Reset
REQ-021 SHALL, while clear=0, force state=IDLE, busy=0, done=0, data_out=0, count=0 and work register=0, regardless of clock.
REQ-022 SHALL abandon an in-progress operation on clear assertion without producing done.
REQ-023 SHALL accept start on the first rising edge after clear deasserts.

Configuration
REQ-024 SHALL compile ror/rol support only when macro SHIFT_SEQ_ROTATE_EN is defined.
REQ-025 SHALL, without SHIFT_SEQ_ROTATE_EN, treat op 011 and 100 as unsupported per REQ-020 and contain no rotate datapath.

Structure
REQ-026 SHALL take op code constants, the state encoding, and the STEP_BITS legal-value check from shared package shift_pkg.
REQ-027 SHALL place the single-step datapath in combinational sub-module shift_step, with inputs value, op and step count, and output the shifted value.

Verification
REQ-028 SHALL cover: shr, data_in=5, shift_amount=3 -> data_out=0x00000000 with done after 5 cycles (STEP_BITS=1).
REQ-029 SHALL cover: shr, data_in=6, shift_amount=1 -> data_out=0x00000003; shra, data_in=0x80000000, shift_amount=4 -> data_out=0xF8000000.
REQ-030 SHALL cover: shl, data_in=0x00000001, shift_amount=40 -> data_out=0x00000000 after 33 SHIFT cycles; shift_amount=-3 -> data_out=data_in, done after edge k+1.
REQ-031 SHALL cover: with SHIFT_SEQ_ROTATE_EN, ror, data_in=0x00000001, shift_amount=33 -> data_out=0x80000000; without the macro, same stimulus -> data_out=0x00000001.
REQ-032 SHALL cover: start pulsed while busy=1 -> ignored, first result unaffected; clear=0 mid-SHIFT -> busy=0, data_out=0, no done pulse.
REQ-033 SHALL cover: STEP_BITS=4, shr, data_in=0xFFFFFFFF, shift_amount=10 -> data_out=0x003FFFFF with 3 SHIFT shift cycles.
